// File: rtl/fifo_pkg.sv
// Shared FIFO constants, helpers and pointer type for the single-clock FIFO family.
// Pure definitions: no logic, no latency, no flow control.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    localparam int FIFO_ADDR_WIDTH_DEF = 3;

    // One extra MSB over the address distinguishes full from empty.
    typedef logic [FIFO_ADDR_WIDTH_DEF:0] fifo_ptr_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// D x DATA_WIDTH storage array: synchronous write, combinational read.
// Read is zero latency; no flow control, the caller gates we_i.
module fifo_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with std/FWFT read, occupancy, thresholds, flush and sticky errors.
// Read latency 1 (std) or 0 (FWFT); writes refused when full, reads refused when empty.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t count_q, count_d;
    logic full_q, empty_q;
    logic overflow_q, underflow_q;
    logic wa, ra;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Flush wins over both requests so a dropped request never touches the flags.
    assign wa = wr_en & ~full_q & ~flush;
    assign ra = rd_en & ~empty_q & ~flush;

    always_comb begin
        wptr_d  = flush ? '0 : wptr_q + ptr_t'(wa);
        rptr_d  = flush ? '0 : rptr_q + ptr_t'(ra);
        count_d = wptr_d - rptr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == ptr_t'(DEPTH));
            empty_q     <= (count_d == '0);
            overflow_q  <= flush ? 1'b0 : (overflow_q | (wr_en & full_q));
            underflow_q <= flush ? 1'b0 : (underflow_q | (rd_en & empty_q));
        end
    end

    fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .we_i    (wa),
        .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (mem_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign rd_data  = mem_rdata;
            assign rd_valid = ~empty_q;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // rd_data deliberately survives flush; only reset clears it.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= ra;
                    if (ra) begin
                        rd_data_q <= mem_rdata;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives one standard-mode and one FWFT instance with identical stimulus against a queue model.
module tb_sync_fifo_flex;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW:0]   af_th;
    logic [AW:0]   ae_th;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae;
    logic [AW:0]   s_count, f_count;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .af_thresh(af_th), .ae_thresh(ae_th), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .af_thresh(af_th), .ae_thresh(ae_th), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [DW-1:0] mq [$];
    logic [DW-1:0] sb [$];
    bit            m_ovf, m_unf, s_vld_exp;
    logic [DW-1:0] s_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz;
        logic [DW-1:0] exp_d;
        sz = mq.size();
        check("s_count", 32'(s_count), sz);
        check("f_count", 32'(f_count), sz);
        check("s_full", 32'(s_full), 32'(sz == D));
        check("f_full", 32'(f_full), 32'(sz == D));
        check("s_empty", 32'(s_empty), 32'(sz == 0));
        check("f_empty", 32'(f_empty), 32'(sz == 0));
        check("s_afull", 32'(s_af), 32'(sz >= int'(af_th)));
        check("f_afull", 32'(f_af), 32'(sz >= int'(af_th)));
        check("s_aempty", 32'(s_ae), 32'(sz <= int'(ae_th)));
        check("f_aempty", 32'(f_ae), 32'(sz <= int'(ae_th)));
        check("s_ovf", 32'(s_ovf), 32'(m_ovf));
        check("f_ovf", 32'(f_ovf), 32'(m_ovf));
        check("s_unf", 32'(s_unf), 32'(m_unf));
        check("f_unf", 32'(f_unf), 32'(m_unf));
        check("s_rd_valid", 32'(s_rd_valid), 32'(s_vld_exp));
        check("s_rd_data_hold", 32'(s_rd_data), 32'(s_last));
        if (s_rd_valid) begin
            if (sb.size() == 0) begin
                check("s_sb_underrun", sb.size(), 1);
            end else begin
                exp_d = sb.pop_front();
                check("s_sb_data", 32'(s_rd_data), 32'(exp_d));
            end
        end
        check("f_rd_valid", 32'(f_rd_valid), 32'(sz != 0));
        if (sz != 0) check("f_rd_data", 32'(f_rd_data), 32'(mq[0]));
    endtask

    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit fl);
        bit mfull, mempty, wa, ra;
        @(negedge clk);
        wr_en = wr; wr_data = wd; rd_en = rd; flush = fl;
        @(posedge clk);
        mfull  = (mq.size() == D);
        mempty = (mq.size() == 0);
        wa = wr && !mfull && !fl;
        ra = rd && !mempty && !fl;
        if (fl) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (wr && mfull) m_ovf = 1;
            if (rd && mempty) m_unf = 1;
        end
        s_vld_exp = ra;
        if (ra) begin
            s_last = mq.pop_front();
            sb.push_back(s_last);
        end
        if (wa) mq.push_back(wd);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 0; rd_en = 0; flush = 0; wr_data = '0;
        rst = 0;
        #1;
        mq.delete();
        sb.delete();
        m_ovf = 0; m_unf = 0; s_vld_exp = 0; s_last = '0;
        check_state();
        @(negedge clk);
        check_state();
        rst = 1;
    endtask

    initial begin
        rst = 1; flush = 0; wr_en = 0; rd_en = 0; wr_data = '0;
        af_th = 4'(D); ae_th = '0;
        m_ovf = 0; m_unf = 0; s_vld_exp = 0; s_last = '0;
        #2;
        do_reset();

        // Fill, then overflow with 0xAA which must never appear in the drain.
        for (int i = 1; i <= D; i++) step(1, DW'(i), 0, 0);
        step(1, 8'hAA, 0, 0);
        step(0, 8'h00, 0, 0);
        for (int i = 0; i < D; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        check("drain_sb_empty", sb.size(), 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'h33, 1, 1);

        // Hold occupancy at 4 across several pointer wraps.
        for (int i = 0; i < 4; i++) step(1, DW'(8'h10 + i), 0, 0);
        for (int i = 0; i < 20; i++) step(1, DW'(8'h20 + i), 1, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h00, 1, 1);

        // Single word into an empty FIFO, then pop.
        step(1, 8'h5A, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        af_th = 4'd6; ae_th = 4'd2;
        for (int i = 0; i < 6; i++) step(1, DW'(8'h60 + i), 0, 0);
        step(1, 8'h77, 0, 1);

        af_th = '0; ae_th = 4'(D);
        for (int i = 0; i < 10; i++) step(1, DW'(8'h80 + i), 0, 0);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0);

        // Async reset in the middle of traffic.
        for (int i = 0; i < 5; i++) step(1, DW'(8'h90 + i), i[0], 0);
        do_reset();
        step(0, 8'h00, 1, 0);

        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                af_th = 4'($urandom_range(0, D));
                ae_th = 4'($urandom_range(0, D));
            end
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Single-clock, fully parametrised FIFO for intra-domain buffering. It sits alongside the dual-clock FIFO and is used wherever producer and consumer share clk. It extends the basic FIFO with:
- selectable standard or first-word-fall-through (FWFT) read mode
- occupancy count
- programmable almost-full and almost-empty thresholds
- synchronous flush
- sticky overflow and underflow error flags

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 3, address bits; depth D = 2**ADDR_WIDTH (default 8)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of contents and flags
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read (pop) request
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data qualifier
full  out  1  count == D
empty  out  1  count == 0
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh
af_thresh  in  ADDR_WIDTH+1  almost-full threshold (quasi-static)
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold (quasi-static)
count  out  ADDR_WIDTH+1  current occupancy, 0..D
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=0, async):
  - wptr, rptr, count = 0; empty=1; full=0; rd_data=0; rd_valid=0; overflow=0; underflow=0.
  - almost_* follow count=0 combinationally.
  - Memory contents are not reset.
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bit binary and wrap modulo 2*D.
  - Memory is indexed by the low ADDR_WIDTH bits.
  - count = wptr - rptr, computed modulo 2**(ADDR_WIDTH+1), and held registered.
- Write accept: wa = wr_en & ~full. On accept: mem[wptr] <= wr_data; wptr increments.
- Read accept: ra = rd_en & ~empty. On accept: rptr increments.
- Simultaneous wa & ra: count unchanged. Read and write on the same edge are legal at any occupancy.
- Full rules:
  - A write while full is refused, even if a read is accepted the same cycle.
  - wr_en & full sets overflow. It does not corrupt data or pointers.
- Empty rules:
  - A read while empty is refused. rd_en & empty sets underflow.
  - Pointers, rd_data and rd_valid are unaffected.
- full, empty and count are registered from next-state values. A write on edge N makes empty=0 immediately after edge N.
- almost_full and almost_empty:
  - Combinational compares of registered count against the threshold inputs, unsigned.
  - af_thresh=0 gives almost_full constantly 1.
  - ae_thresh >= D gives almost_empty constantly 1.
- FWFT=0 (standard mode):
  - On ra at edge N, rd_data <= mem[rptr] and rd_valid=1 for the cycle after edge N.
  - Otherwise rd_valid=0 and rd_data holds its last value.
  - Read latency: 1 cycle.
- FWFT=1:
  - rd_data = mem[rptr], combinational read of the register array; rd_valid = ~empty.
  - rd_en acts as acknowledge/pop of the displayed word.
  - A word written at edge N is visible on rd_data after edge N when the FIFO was empty.
- flush=1 at an edge:
  - wptr, rptr, count = 0; empty=1; full=0; rd_valid=0; overflow=0; underflow=0.
  - Takes priority over simultaneous wr_en and rd_en. These requests are dropped and do not set error flags.
  - rd_data holds its value.
- Reset mid-operation: immediate async clear as above. The FIFO is empty on rst release.

Decomposition:
- Package fifo_pkg:
  - FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1 constants.
  - Function clog2.
  - Pointer/count typedef sized ADDR_WIDTH+1.
- Sub-module fifo_regfile:
  - D x DATA_WIDTH register array with synchronous write.
  - Combinational read port addressed by rptr[ADDR_WIDTH-1:0].
  - Top level owns pointers, flags, output register and mode mux.

Test Plan:
- Reset then fill (FWFT=0, D=8): write 0x01..0x08 on consecutive cycles → count steps 1..8; full=1 after the 8th edge; empty=0 after the 1st edge.
- Overflow: with full=1, assert wr_en with 0xAA → overflow=1, count stays 8, a later drain returns 0x01..0x08 with no 0xAA.
- Standard drain and underflow: pop 8 times → rd_data 0x01..0x08, each with rd_valid 1 cycle after accept; then rd_en on empty → underflow=1, rd_valid=0.
- Wrap and simultaneous access: hold count=4 and do 20 cycles of simultaneous wr/rd with an incrementing pattern → count stays 4, data in order across pointer wrap, no flags set.
- FWFT=1: write 0x5A into empty FIFO → rd_data=0x5A, rd_valid=1 after that edge; rd_en pops; empty=1 next edge.
- Thresholds and flush: af_thresh=6, ae_thresh=2; fill to 6 → almost_full=1 at count 6, almost_empty=0 at count 3; flush with wr_en=1 → count=0, empty=1, overflow and underflow both 0.
